// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks the select of a downstream 16:1 mux through 0..15,
// waits SETTLE_CYCLES after each select change, samples f_in into a shadow
// word and presents the completed word with a valid/ready handshake.
// Optional feature: define MUX_SCAN_PARITY_EN to add the parity_out port.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        f_in,
    input  logic        out_ready,
    output logic [3:0]  sel,
    output logic        busy,
    output logic [15:0] data_out,
    output logic        out_valid
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic        parity_out
`endif
);

    localparam int unsigned SEL_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 3;

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
`ifdef MUX_SCAN_PARITY_EN
    logic                parity_q, parity_d;
`endif

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic: one scan per start, leave HOLD on the handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = SCAN;
            SCAN: if ((cnt_q == '0) && (sel_q == SEL_LAST)) state_d = HOLD;
            HOLD: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath/output logic: settle countdown, bit capture, word hand-off.
    always_comb begin
        logic [DATA_W-1:0] shadow_cap;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        data_d     = data_q;
        valid_d    = valid_q;
        shadow_cap = shadow_q;
        shadow_cap[sel_q] = f_in;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d    = '0;
                    cnt_d    = SETTLE_LD;
                    shadow_d = '0;
                end
            end
            SCAN: begin
                if (cnt_q == '0) begin
                    shadow_d = shadow_cap;
                    if (sel_q != SEL_LAST) begin
                        sel_d = sel_q + SEL_W'(1);
                        cnt_d = SETTLE_LD;
                    end else begin
                        data_d  = shadow_cap;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
`ifdef MUX_SCAN_PARITY_EN
        parity_d = ^data_d;
`endif
    end

    assign sel       = sel_q;
    assign busy      = busy_q;
    assign data_out  = data_q;
    assign out_valid = valid_q;
`ifdef MUX_SCAN_PARITY_EN
    assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: table of full scans on a SETTLE_CYCLES=1 instance,
// plus hand sequences for reset mid-scan and SETTLE_CYCLES=0.
module tb_mux_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset;

    logic        start1, f_in1, out_ready1, busy1, out_valid1;
    logic [3:0]  sel1;
    logic [15:0] data_out1, w1;

    logic        start0, f_in0, out_ready0, busy0, out_valid0;
    logic [3:0]  sel0;
    logic [15:0] data_out0, w0;

`ifdef MUX_SCAN_PARITY_EN
    logic        parity_out1, parity_out0;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    // 16:1 mux models driven by each DUT's select
    always_comb f_in1 = w1[sel1];
    always_comb f_in0 = w0[sel0];

    mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .f_in(f_in1),
        .out_ready(out_ready1), .sel(sel1), .busy(busy1),
        .data_out(data_out1), .out_valid(out_valid1)
`ifdef MUX_SCAN_PARITY_EN
        , .parity_out(parity_out1)
`endif
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .f_in(f_in0),
        .out_ready(out_ready0), .sel(sel0), .busy(busy0),
        .data_out(data_out0), .out_valid(out_valid0)
`ifdef MUX_SCAN_PARITY_EN
        , .parity_out(parity_out0)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    typedef struct {
        logic [15:0] w;
        logic [15:0] exp_data;
        logic        exp_par;
        int          glitch_cyc;   // 0 = no extra start pulse during the scan
        int          hold_cycles;  // cycles out_ready stays low in HOLD
        bit          hs_start;     // raise start during the handshake cycle
    } vec_t;

    logic [15:0] prev_word;

    // One full scan on dut1 with latency, hold and handshake checks.
    task automatic run_scan1(input vec_t v);
        int cyc;
        w1     = v.w;
        start1 = 1'b1;
        cyc    = 0;
        do begin
            @(posedge clock);
            cyc++;
            #1;
            if (cyc == 1) begin
                start1 = 1'b0;
                check("scan_busy", 32'(busy1), 32'd1);
                check("scan_sel0", 32'(sel1), 32'd0);
            end
            if (v.glitch_cyc != 0 && cyc == v.glitch_cyc) start1 = 1'b1;
            if (v.glitch_cyc != 0 && cyc == v.glitch_cyc + 1) start1 = 1'b0;
            if (cyc == 10) check("data_kept_in_scan", 32'(data_out1), 32'(prev_word));
        end while (!out_valid1 && cyc < 100);
        start1 = 1'b0;
        check("latency", 32'(cyc), 32'd33);
        check("data_out", 32'(data_out1), 32'(v.exp_data));
        check("sel_hold", 32'(sel1), 32'd15);
`ifdef MUX_SCAN_PARITY_EN
        check("parity_out", 32'(parity_out1), 32'(v.exp_par));
`endif
        for (int i = 0; i < v.hold_cycles; i++) begin
            @(posedge clock);
            #1;
            check("hold_valid", 32'(out_valid1), 32'd1);
            check("hold_data", 32'(data_out1), 32'(v.exp_data));
            check("hold_sel", 32'(sel1), 32'd15);
        end
        out_ready1 = 1'b1;
        start1     = v.hs_start;
        @(posedge clock);
        #1;
        out_ready1 = 1'b0;
        start1     = 1'b0;
        check("release_valid", 32'(out_valid1), 32'd0);
        check("release_busy", 32'(busy1), 32'd0);
        check("release_data", 32'(data_out1), 32'(v.exp_data));
        @(posedge clock);
        #1;
        check("idle_busy", 32'(busy1), 32'd0);
        check("idle_sel", 32'(sel1), 32'd15);
        prev_word = v.exp_data;
    endtask

    vec_t vecs[6];

    initial begin
        vec_t vr;
        int   cyc;

        vecs[0] = '{w: 16'hA5C3, exp_data: 16'hA5C3, exp_par: 1'b0, glitch_cyc: 0, hold_cycles: 10, hs_start: 1'b0};
        vecs[1] = '{w: 16'h0001, exp_data: 16'h0001, exp_par: 1'b1, glitch_cyc: 5, hold_cycles: 2,  hs_start: 1'b1};
        vecs[2] = '{w: 16'h1234, exp_data: 16'h1234, exp_par: 1'b1, glitch_cyc: 0, hold_cycles: 0,  hs_start: 1'b0};
        vecs[3] = '{w: 16'h0000, exp_data: 16'h0000, exp_par: 1'b0, glitch_cyc: 20, hold_cycles: 1, hs_start: 1'b1};
        vecs[4] = '{w: 16'h8000, exp_data: 16'h8000, exp_par: 1'b1, glitch_cyc: 0, hold_cycles: 3,  hs_start: 1'b0};
        vecs[5] = '{w: 16'h5A5A, exp_data: 16'h5A5A, exp_par: 1'b0, glitch_cyc: 0, hold_cycles: 0,  hs_start: 1'b0};

        reset = 1'b1;
        start1 = 1'b0; out_ready1 = 1'b1; w1 = 16'hFFFF;
        start0 = 1'b0; out_ready0 = 1'b0; w0 = 16'h0000;
        prev_word = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_sel", 32'(sel1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_data", 32'(data_out1), 32'd0);
        check("rst_valid", 32'(out_valid1), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
        check("rst_parity", 32'(parity_out1), 32'd0);
`endif
        // out_ready is ignored while idle
        @(posedge clock);
        #1;
        out_ready1 = 1'b0;
        check("idle_ready_ignored", 32'(busy1), 32'd0);

        for (int i = 0; i < 6; i++) run_scan1(vecs[i]);

        // SETTLE_CYCLES=0: sel steps every cycle, valid after 17 edges
        w0     = 16'h8000;
        start0 = 1'b1;
        cyc    = 0;
        do begin
            @(posedge clock);
            cyc++;
            #1;
            start0 = 1'b0;
            if (cyc <= 16) check("s0_sel_step", 32'(sel0), 32'(cyc - 1));
        end while (!out_valid0 && cyc < 60);
        check("s0_latency", 32'(cyc), 32'd17);
        check("s0_data", 32'(data_out0), 32'h8000);
        check("s0_sel_last", 32'(sel0), 32'd15);
`ifdef MUX_SCAN_PARITY_EN
        check("s0_parity", 32'(parity_out0), 32'd1);
`endif
        out_ready0 = 1'b1;
        @(posedge clock);
        #1;
        out_ready0 = 1'b0;
        check("s0_release", 32'(busy0), 32'd0);

        // Reset 20 cycles into a scan, then a fresh scan completes normally
        w1     = 16'h3C3C;
        start1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            start1 = 1'b0;
        end
        check("pre_rst_busy", 32'(busy1), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midrst_sel", 32'(sel1), 32'd0);
        check("midrst_busy", 32'(busy1), 32'd0);
        check("midrst_data", 32'(data_out1), 32'd0);
        check("midrst_valid", 32'(out_valid1), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
        check("midrst_parity", 32'(parity_out1), 32'd0);
`endif
        prev_word = 16'h0000;
        vr = '{w: 16'hFFFF, exp_data: 16'hFFFF, exp_par: 1'b0, glitch_cyc: 0, hold_cycles: 2, hs_start: 1'b0};
        run_scan1(vr);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
